// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register-file write-back arbiter
//
// Purpose: register-file geometry, the hard-wired zero register, and the
//          grant encoding used by the round-robin arbiter.
// Ports:   none (package).

package regfile_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int REG_COUNT = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// rtl/regfile_wb_fifo.sv - small circular FIFO holding pending register writes
//
// Purpose: buffers {addr, data} write-back entries for one requester.
// Ports:   Clk, Reset  - clock, asynchronous active-high reset
//          push        - write push_data at the tail (caller ensures not full)
//          push_data   - entry to store
//          pop         - drop the head entry (caller ensures not empty)
//          head        - current head entry
//          count       - number of stored entries
//          empty       - no entries stored

module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester write-back arbiter with pending-write scoreboard
//
// Purpose: shares the single register-file write port between requester A
//          (ALU) and B (load) through per-requester FIFOs and a round-robin
//          arbiter, and tracks in-flight writes per register.
// Ports:   Clk, Reset            - clock, asynchronous active-high reset
//          a_valid/a_ready       - requester A handshake, a_addr/a_data payload
//          b_valid/b_ready       - requester B handshake, b_addr/b_data payload
//          rsv_valid/rsv_addr    - issue stage reserves a destination register
//          q_addr_x/q_busy_x     - scoreboard queries (combinational)
//          W_Addr/W_Data/Write_Reg - registered register-file write port
//          sb_err                - sticky counter overflow/underflow flag

module regfile_wb_arbiter #(
  parameter int DATA_W     = regfile_pkg::DATA_W,
  parameter int ADDR_W     = regfile_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic [ADDR_W-1:0] q_addr_a,
  input  logic [ADDR_W-1:0] q_addr_b,
  output logic              q_busy_a,
  output logic              q_busy_b,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              Write_Reg,
  output logic              sb_err
);

  import regfile_pkg::*;

  localparam int EW   = ADDR_W + DATA_W;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);

  logic [EW-1:0] a_head, b_head;
  logic [CW-1:0] a_count, b_count;
  logic          a_empty, b_empty;
  logic          a_push, b_push;
  logic          gnt_a, gnt_b;
  grant_t        last_grant;
  logic [EW-1:0] win;

  // Ready comes only from the registered count; a pop in the same cycle
  // does not make room early.
  assign a_ready = (a_count != CW'(FIFO_DEPTH));
  assign b_ready = (b_count != CW'(FIFO_DEPTH));
  assign a_push  = a_valid && a_ready;
  assign b_push  = b_valid && b_ready;

  wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo_a (
    .Clk(Clk), .Reset(Reset),
    .push(a_push), .push_data({a_addr, a_data}),
    .pop(gnt_a), .head(a_head), .count(a_count), .empty(a_empty)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo_b (
    .Clk(Clk), .Reset(Reset),
    .push(b_push), .push_data({b_addr, b_data}),
    .pop(gnt_b), .head(b_head), .count(b_count), .empty(b_empty)
  );

  // A wins when alone, or when both wait and B was served last.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!a_empty && (b_empty || last_grant == GNT_B)) gnt_a = 1'b1;
    else if (!b_empty)                                 gnt_b = 1'b1;
  end

  assign win = gnt_a ? a_head : b_head;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_grant <= GNT_B;
      Write_Reg  <= 1'b0;
      W_Addr     <= '0;
      W_Data     <= '0;
    end else begin
      // Zero-register entries use their slot but never strobe the write.
      Write_Reg <= (gnt_a || gnt_b) && (win[EW-1:DATA_W] != ZERO_A);
      if (gnt_a || gnt_b) begin
        W_Addr     <= win[EW-1:DATA_W];
        W_Data     <= win[DATA_W-1:0];
        last_grant <= gnt_a ? GNT_A : GNT_B;
      end
    end
  end

  // Scoreboard: the decrement happens at the edge the register file writes.
  // Write_Reg is never high for register 0 and reservations of register 0
  // are ignored, so pend[0] stays zero.
  logic [CNT_W-1:0] pend     [NREG];
  logic [CNT_W-1:0] pend_nxt [NREG];
  logic             inc_en, dec_en, err_nxt;

  assign inc_en = rsv_valid && (rsv_addr != ZERO_A);
  assign dec_en = Write_Reg;

  always_comb begin
    pend_nxt = pend;
    err_nxt  = 1'b0;
    // inc and dec on the same register cancel out.
    if (!(inc_en && dec_en && rsv_addr == W_Addr)) begin
      if (inc_en) begin
        if (pend[rsv_addr] == CNT_MAX) err_nxt = 1'b1;
        else                           pend_nxt[rsv_addr] = pend[rsv_addr] + 1'b1;
      end
      if (dec_en) begin
        if (pend[W_Addr] == '0) err_nxt = 1'b1;
        else                    pend_nxt[W_Addr] = pend[W_Addr] - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
      sb_err <= 1'b0;
    end else begin
      pend   <= pend_nxt;
      sb_err <= sb_err | err_nxt;
    end
  end

  assign q_busy_a = (pend[q_addr_a] != '0);
  assign q_busy_b = (pend[q_addr_b] != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        a_valid, b_valid, rsv_valid;
  logic        a_ready, b_ready, q_busy_a, q_busy_b, Write_Reg, sb_err;
  logic [4:0]  a_addr, b_addr, rsv_addr, q_addr_a, q_addr_b, W_Addr;
  logic [31:0] a_data, b_data, W_Data;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .CNT_W(3)) dut (
    .Clk(Clk), .Reset(Reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .q_addr_a(q_addr_a), .q_addr_b(q_addr_b), .q_busy_a(q_busy_a), .q_busy_b(q_busy_b),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg), .sb_err(sb_err)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  bit run   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queues of {addr,data}, a per-register pending count,
  // and the last served side.
  logic [36:0] mq_a[$], mq_b[$];
  int          mcnt[32];
  bit          m_err = 0, m_wr = 0, m_last_b = 1, m_acc_a = 0, m_acc_b = 0;
  logic [4:0]  m_wa = '0;
  logic [31:0] m_wd = '0;
  int          rstate[32];   // random phase: 0 free, 1 reserved, 2 presented
  bit          old_wr, g;
  logic [4:0]  old_wa;
  logic [36:0] e;
  int          inc_r, dec_r;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mq_a.delete();
      mq_b.delete();
      for (int i = 0; i < 32; i++) begin mcnt[i] = 0; rstate[i] = 0; end
      m_err = 0; m_wr = 0; m_wa = '0; m_wd = '0; m_last_b = 1;
      m_acc_a = 0; m_acc_b = 0;
    end else begin
      old_wr  = m_wr;
      old_wa  = m_wa;
      m_acc_a = a_valid && (mq_a.size() < DEPTH);
      m_acc_b = b_valid && (mq_b.size() < DEPTH);
      g = 0;
      if (mq_a.size() > 0 && (mq_b.size() == 0 || m_last_b)) begin
        e = mq_a.pop_front(); m_last_b = 0; g = 1;
      end else if (mq_b.size() > 0) begin
        e = mq_b.pop_front(); m_last_b = 1; g = 1;
      end
      m_wr = g && (e[36:32] != 0);
      if (g) begin m_wa = e[36:32]; m_wd = e[31:0]; end
      if (m_acc_a) mq_a.push_back({a_addr, a_data});
      if (m_acc_b) mq_b.push_back({b_addr, b_data});
      inc_r = (rsv_valid && rsv_addr != 0) ? int'(rsv_addr) : 0;
      dec_r = old_wr ? int'(old_wa) : 0;
      if (!(inc_r != 0 && inc_r == dec_r)) begin
        if (inc_r != 0) begin
          if (mcnt[inc_r] == 7) m_err = 1; else mcnt[inc_r]++;
        end
        if (dec_r != 0) begin
          if (mcnt[dec_r] == 0) m_err = 1; else mcnt[dec_r]--;
        end
      end
      if (dec_r != 0) rstate[dec_r] = 0;
    end
  end

  always @(negedge Clk) begin
    if (run && !Reset) begin
      chk("a_ready", a_ready, mq_a.size() != DEPTH);
      chk("b_ready", b_ready, mq_b.size() != DEPTH);
      chk("Write_Reg", Write_Reg, m_wr);
      if (m_wr) begin
        chk("W_Addr", W_Addr, m_wa);
        chk("W_Data", W_Data, m_wd);
      end
      chk("q_busy_a", q_busy_a, mcnt[q_addr_a] != 0);
      chk("q_busy_b", q_busy_b, mcnt[q_addr_b] != 0);
      chk("sb_err", sb_err, m_err);
    end
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; rsv_valid = 0;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1;
    cyc();
    Reset = 0;
  endtask

  function automatic int pick_reserved();
    int c[$];
    for (int r = 1; r < 32; r++) if (rstate[r] == 1) c.push_back(r);
    if (c.size() == 0) return -1;
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  int p;

  initial begin
    idle();
    a_addr = 0; a_data = 0; b_addr = 0; b_data = 0; rsv_addr = 0;
    q_addr_a = 0; q_addr_b = 0;
    #1 Reset = 1;
    cyc(); cyc();
    Reset = 0;
    run = 1;
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_Write_Reg", Write_Reg, 0);
    chk("rst_W_Addr", W_Addr, 0);
    chk("rst_W_Data", W_Data, 0);
    chk("rst_sb_err", sb_err, 0);

    // Reset mid-stream with A full
    a_valid = 1; a_addr = 10; a_data = 32'hAAAA_0010;
    b_valid = 1; b_addr = 11; b_data = 32'hBBBB_0011;
    rsv_valid = 1; rsv_addr = 12;
    cyc(); cyc(); cyc();
    chk("midrst_a_full", a_ready, 0);
    do_reset();
    chk("midrst_a_ready", a_ready, 1);
    chk("midrst_Write_Reg", Write_Reg, 0);
    chk("midrst_sb_err", sb_err, 0);
    for (int i = 0; i < 16; i++) begin
      q_addr_a = 5'(i); q_addr_b = 5'(i + 16);
      #1;
      chk("midrst_busy_a", q_busy_a, 0);
      chk("midrst_busy_b", q_busy_b, 0);
      cyc();
    end

    // Contention: A r1,r2 / B r3,r4 -> r1,r3,r2,r4
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      rsv_valid = 1; rsv_addr = 5'(r); cyc();
    end
    rsv_valid = 0;
    a_valid = 1; a_addr = 1; a_data = 32'h101; b_valid = 1; b_addr = 3; b_data = 32'h103;
    cyc();
    a_addr = 2; a_data = 32'h102; b_addr = 4; b_data = 32'h104;
    cyc();
    idle();
    chk("rr_1_we", Write_Reg, 1); chk("rr_1_addr", W_Addr, 1); chk("rr_1_data", W_Data, 32'h101);
    cyc();
    chk("rr_2_we", Write_Reg, 1); chk("rr_2_addr", W_Addr, 3); chk("rr_2_data", W_Data, 32'h103);
    cyc();
    chk("rr_3_we", Write_Reg, 1); chk("rr_3_addr", W_Addr, 2);
    cyc();
    chk("rr_4_we", Write_Reg, 1); chk("rr_4_addr", W_Addr, 4);
    cyc();
    chk("rr_end_we", Write_Reg, 0);

    // Single push latency
    rsv_valid = 1; rsv_addr = 5; cyc(); rsv_valid = 0;
    a_valid = 1; a_addr = 5; a_data = 32'h1234_5678;
    cyc();
    a_valid = 0;
    chk("lat_n_we", Write_Reg, 0);
    cyc();
    chk("lat_n1_we", Write_Reg, 1); chk("lat_n1_addr", W_Addr, 5); chk("lat_n1_data", W_Data, 32'h1234_5678);
    cyc();
    chk("lat_n2_we", Write_Reg, 0);

    // Scoreboard r7
    rsv_valid = 1; rsv_addr = 7; cyc(); rsv_valid = 0;
    q_addr_a = 7; #1;
    chk("r7_busy_rsv", q_busy_a, 1);
    b_valid = 1; b_addr = 7; b_data = 32'h77;
    cyc(); b_valid = 0;
    cyc();
    chk("r7_we", Write_Reg, 1); chk("r7_addr", W_Addr, 7); chk("r7_busy_wcycle", q_busy_a, 1);
    cyc();
    chk("r7_busy_after", q_busy_a, 0);
    rsv_valid = 1; rsv_addr = 7; cyc(); rsv_valid = 0;
    b_valid = 1; b_addr = 7; cyc(); b_valid = 0;
    cyc();
    rsv_valid = 1; rsv_addr = 7;
    cyc(); rsv_valid = 0;
    chk("r7_same_cycle_busy", q_busy_a, 1);
    b_valid = 1; b_addr = 7; cyc(); b_valid = 0;
    cyc(); cyc();
    chk("r7_drained", q_busy_a, 0);

    // Address 0 entry
    a_valid = 1; a_addr = 0; a_data = 32'hFFFF_FFFF;
    cyc(); a_valid = 0;
    chk("z_n_we", Write_Reg, 0);
    cyc();
    chk("z_n1_we", Write_Reg, 0);
    cyc();
    chk("z_n2_we", Write_Reg, 0);
    chk("z_sb_err", sb_err, 0);

    // Unreserved write and overflow on r9
    a_valid = 1; a_addr = 9; a_data = 32'h99;
    cyc(); a_valid = 0;
    cyc();
    chk("r9_err_before", sb_err, 0);
    cyc();
    chk("r9_err_set", sb_err, 1);
    cyc(); cyc(); cyc();
    chk("r9_err_sticky", sb_err, 1);
    rsv_valid = 1; rsv_addr = 9;
    repeat (8) cyc();
    rsv_valid = 0;
    q_addr_a = 9;
    a_valid = 1; a_addr = 9;
    repeat (7) cyc();
    a_valid = 0;
    cyc();
    chk("r9_cnt_one_left", q_busy_a, 1);
    cyc();
    chk("r9_cnt_zero", q_busy_a, 0);
    chk("r9_err_final", sb_err, 1);

    // Randomised traffic with consistent reservations
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (!(a_valid && !m_acc_a)) begin
        a_valid = 0;
        if ($urandom_range(0, 1) == 1) begin
          a_data = $urandom;
          if ($urandom_range(0, 7) == 0) begin a_valid = 1; a_addr = 0; end
          else begin
            p = pick_reserved();
            if (p > 0) begin a_valid = 1; a_addr = 5'(p); rstate[p] = 2; end
          end
        end
      end
      if (!(b_valid && !m_acc_b)) begin
        b_valid = 0;
        if ($urandom_range(0, 1) == 1) begin
          b_data = $urandom;
          if ($urandom_range(0, 7) == 0) begin b_valid = 1; b_addr = 0; end
          else begin
            p = pick_reserved();
            if (p > 0) begin b_valid = 1; b_addr = 5'(p); rstate[p] = 2; end
          end
        end
      end
      rsv_valid = 0;
      rsv_addr  = 5'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        p = $urandom_range(1, 31);
        if (rstate[p] == 0) begin rstate[p] = 1; rsv_valid = 1; rsv_addr = 5'(p); end
      end else if ($urandom_range(0, 15) == 0) begin
        rsv_valid = 1; rsv_addr = 0;
      end
      q_addr_a = 5'($urandom);
      q_addr_b = 5'($urandom);
      cyc();
    end
    idle();
    repeat (6) cyc();
    chk("rand_sb_err", sb_err, 0);
    chk("rand_idle_we", Write_Reg, 0);

    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 MIPS register file (W_Addr/W_Data/Write_Reg) between two write-back requesters: A (ALU result) and B (memory load).
- Each requester pushes into its own small FIFO through a valid/ready handshake. A round-robin arbiter drains one entry per cycle into registered write-port outputs.
- An integrated pending-write scoreboard lets the issue stage ask whether a source register still has a write in flight.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)
- FIFO_DEPTH, 2, entries per requester FIFO (power of 2, >=2)
- CNT_W, 3, width of per-register pending counter

Ports:
- Clk  in  1  clock
- Reset  in  1  asynchronous, active-high reset
- a_valid  in  1  requester A has a write
- a_ready  out  1  A FIFO can accept
- a_addr  in  ADDR_W  A destination register
- a_data  in  DATA_W  A write data
- b_valid  in  1  requester B has a write
- b_ready  out  1  B FIFO can accept
- b_addr  in  ADDR_W  B destination register
- b_data  in  DATA_W  B write data
- rsv_valid  in  1  issue stage reserves a destination
- rsv_addr  in  ADDR_W  reserved register
- q_addr_a  in  ADDR_W  scoreboard query A
- q_addr_b  in  ADDR_W  scoreboard query B
- q_busy_a  out  1  register q_addr_a has a pending write
- q_busy_b  out  1  register q_addr_b has a pending write
- W_Addr  out  ADDR_W  to register-file write address
- W_Data  out  DATA_W  to register-file write data
- Write_Reg  out  1  to register-file write enable
- sb_err  out  1  sticky scoreboard overflow/underflow flag

Behaviour:
- Clocking and reset: reset is Reset, asynchronous, active-high; clock is Clk.
- Reset values: FIFOs empty; a_ready=b_ready=1; Write_Reg=0; W_Addr=0; W_Data=0; all pending counters 0; sb_err=0; last_grant=B, so A wins the first contention.
- Reset mid-operation: discards all FIFO contents and in-flight outputs immediately.
- Push: x_ready = (FIFO count != FIFO_DEPTH), derived from registered count and not from x_valid. An entry is accepted at the edge where x_valid && x_ready. Data/addr must hold while valid && !ready.
- Arbitration: once per cycle, combinational on FIFO non-empty flags.
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the side opposite last_grant.
  - last_grant updates only on an actual grant.
- Pop: the granted head is popped at the edge, and W_Addr/W_Data/Write_Reg are registered from it. Write_Reg is high for exactly one cycle per entry with nonzero address.
- Address 0: an entry with addr 0 is popped normally and consumes its grant slot, but drives Write_Reg=0.
- Latency: push at edge N, empty FIFO, no contention → Write_Reg=1 during cycle after edge N+1; register file writes at edge N+2.
- Throughput: 1 write per cycle combined.
- Simultaneous push and pop on the same FIFO: count unchanged. A full FIFO popped this cycle still shows ready=0 this cycle (no bypass).
- Scoreboard: one CNT_W counter per register 1..31; register 0 is never busy.
  - inc = rsv_valid && rsv_addr!=0.
  - dec = Write_Reg && W_Addr matches the counter, i.e. at the edge the register file actually writes.
  - inc and dec on the same register in the same cycle: counter unchanged.
  - inc at max value: counter unchanged, sb_err set.
  - dec at 0: counter unchanged, sb_err set.
  - sb_err clears only on Reset.
- Query: q_busy_x = (counter[q_addr_x] != 0), combinational. Reflects the value before the current edge; no forwarding of same-cycle reserve/clear.
- No ordering is guaranteed between A and B writes to the same register. The issue stage must not reserve a register twice across both requesters.

Decomposition:
- Shared package regfile_pkg: ADDR_W, DATA_W, REG_COUNT=32, ZERO_REG=0, grant enum {GNT_A, GNT_B}.
- One natural sub-module: wb_fifo (parameterised depth/width, push/pop, count, full/empty), instantiated twice.
- Arbiter and scoreboard stay in the top.

Test Plan:
- Reset mid-stream with A FIFO full → next cycle: a_ready=1, Write_Reg=0, q_busy for all registers 0, sb_err=0.
- Single A push (addr 5, data 0x1234_5678) at edge N → Write_Reg=1, W_Addr=5, W_Data=0x1234_5678 in cycle after edge N+1 only.
- A and B both hold 2 entries (A: r1,r2; B: r3,r4) → Write_Reg sequence r1,r3,r2,r4 on consecutive cycles.
- rsv r7; query r7 busy=1; B writes r7 → q_busy drops in the cycle after the Write_Reg cycle. Same-cycle rsv r7 and write r7 with count 1 → count stays 1.
- Push addr 0 with data 0xFFFF_FFFF → entry drained, Write_Reg stays 0, no counter change.
- Write to r9 with no reservation → sb_err=1 and sticky. 8 reservations of r9 → sb_err=1, counter stays 7.
